// File: rtl/imm_load_expander.sv
// imm_load_expander: rebuilds a 32-bit constant in a register using the shortest
// addiu / ori / lui(+ori) sequence, with valid/ready handshakes on both sides.
module imm_load_expander #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Value,
    input  logic [4:0]       Rt,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      Instr,
    output logic             Last,
    output logic [CNT_W-1:0] WordCnt,
    output logic [CNT_W-1:0] PairCnt
);
    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    state_t           state_q, state_d;
    logic [31:0]      v_q, v_d;
    logic [4:0]       rt_q, rt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d, pair_cnt_q, pair_cnt_d;
    logic             sext, zext, pair, fire, done, accept;

    function automatic logic is_pair(input logic [31:0] v);
        return !(&v[31:15] || ~|v[31:15] || (v[31:16] == 16'd0 && v[15]) || v[15:0] == 16'd0);
    endfunction

    assign sext   = &v_q[31:15] || ~|v_q[31:15];
    assign zext   = v_q[31:16] == 16'd0 && v_q[15];
    assign pair   = is_pair(v_q);
    assign fire   = OutValid && OutReady;
    assign done   = fire && Last;
    assign InReady = state_q == IDLE || done;
    assign accept = InValid && InReady;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            v_q        <= '0;
            rt_q       <= '0;
            word_cnt_q <= '0;
            pair_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            rt_q       <= rt_d;
            word_cnt_q <= word_cnt_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

    // A finished word with a waiting request skips IDLE entirely.
    always_comb begin
        state_d    = accept ? EMIT1 : done ? IDLE : (fire && state_q == EMIT1) ? EMIT2 : state_q;
        v_d        = accept ? Value : v_q;
        rt_d       = accept ? Rt : rt_q;
        word_cnt_d = (fire && !(&word_cnt_q)) ? word_cnt_q + CNT_W'(1) : word_cnt_q;
        pair_cnt_d = (accept && is_pair(Value) && !(&pair_cnt_q)) ? pair_cnt_q + CNT_W'(1) : pair_cnt_q;
    end

    always_comb begin
        OutValid = state_q != IDLE;
        Last     = state_q == EMIT2 || (state_q == EMIT1 && !pair);
        Instr    = state_q == IDLE  ? 32'd0 :
                   state_q == EMIT2 ? {6'b001101, rt_q, rt_q, v_q[15:0]} :
                   sext             ? {6'b001001, 5'd0, rt_q, v_q[15:0]} :
                   zext             ? {6'b001101, 5'd0, rt_q, v_q[15:0]} :
                                      {6'b001111, 5'd0, rt_q, v_q[31:16]};
    end

    assign WordCnt = word_cnt_q;
    assign PairCnt = pair_cnt_q;
endmodule

// File: tb/tb_imm_load_expander.sv
// tb_imm_load_expander: directed and randomized checks of imm_load_expander against
// an instruction-list reference model with a word scoreboard.
module tb_imm_load_expander;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] w;
        logic        l;
    } word_t;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             in_valid = 0, in_ready, out_valid, out_ready = 0, last;
    logic [31:0]      value = 0, instr;
    logic [4:0]       rt = 0;
    logic [CNT_W-1:0] word_cnt, pair_cnt;

    word_t       q[$];
    int          m_words = 0, m_pairs = 0, n_chk = 0, n_pass = 0;
    logic [31:0] obs_instr;
    logic        obs_last;

    imm_load_expander #(.CNT_W(CNT_W)) dut (
        .CLK(clk), .Reset(rst_n), .InValid(in_valid), .InReady(in_ready),
        .Value(value), .Rt(rt), .OutValid(out_valid), .OutReady(out_ready),
        .Instr(instr), .Last(last), .WordCnt(word_cnt), .PairCnt(pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc(input int op, input int rs, input int rtn, input int imm);
        return 32'(op * 67108864 + rs * 2097152 + rtn * 65536 + imm);
    endfunction

    // Shortest sequence chosen from the numeric range of the constant.
    task automatic expand(input logic [31:0] v, input logic [4:0] r);
        longint unsigned u = v;
        int hi = int'(u / 65536), lo = int'(u % 65536);
        if (u <= 64'h7FFF || u >= 64'hFFFF8000) q.push_back('{enc(9, 0, r, lo), 1'b1});
        else if (u <= 64'hFFFF) q.push_back('{enc(13, 0, r, lo), 1'b1});
        else if (lo == 0) q.push_back('{enc(15, 0, r, hi), 1'b1});
        else begin
            q.push_back('{enc(15, 0, r, hi), 1'b0});
            q.push_back('{enc(13, r, r, lo), 1'b1});
            m_pairs = m_pairs == CMAX ? CMAX : m_pairs + 1;
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] v, input logic [4:0] r, input logic ordy);
        logic exp_ready;
        @(negedge clk);
        in_valid = iv; value = v; rt = r; out_ready = ordy;
        #1;
        exp_ready = q.size() == 0 || (q.size() == 1 && ordy);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("word_cnt", 32'(word_cnt), 32'(m_words));
        chk("pair_cnt", 32'(pair_cnt), 32'(m_pairs));
        obs_instr = instr;
        obs_last  = last;
        if (q.size() != 0) begin
            chk("instr", instr, q[0].w);
            chk("last", 32'(last), 32'(q[0].l));
            if (ordy) begin
                void'(q.pop_front());
                m_words = m_words == CMAX ? CMAX : m_words + 1;
            end
        end
        if (iv && exp_ready) expand(v, r);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1;

        cycle(1, 32'hFFFF_FFFE, 8, 1);
        cycle(0, 0, 0, 1);
        chk("sext_word", obs_instr, 32'h2408_FFFE);
        chk("sext_last", 32'(obs_last), 1);
        cycle(1, 32'h0000_8000, 9, 1);
        chk("sext_cnt", 32'(word_cnt), 1);
        cycle(1, 32'h0000_7FFF, 9, 1);
        chk("zext_word", obs_instr, 32'h3409_8000);
        cycle(1, 32'h1234_5678, 10, 1);
        chk("sext_bound", obs_instr, 32'h2409_7FFF);
        cycle(0, 0, 0, 1);
        chk("pair_w1", obs_instr, 32'h3C0A_1234);
        chk("pair_l1", 32'(obs_last), 0);
        cycle(1, 32'hABCD_0000, 11, 1);
        chk("pair_w2", obs_instr, 32'h354A_5678);
        chk("pair_l2", 32'(obs_last), 1);
        cycle(1, 32'h0, 3, 1);
        chk("high_word", obs_instr, 32'h3C0B_ABCD);
        chk("pair_cnt1", 32'(pair_cnt), 1);
        cycle(0, 0, 0, 1);
        chk("zero_word", obs_instr, 32'h2403_0000);

        cycle(1, 32'hABCD_0000, 11, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h5555_AAAA, 4, 0);
            chk("bp_instr", obs_instr, 32'h3C0B_ABCD);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        cycle(1, 32'h0000_8000, 9, 1);
        cycle(0, 0, 0, 1);
        chk("b2b_word", obs_instr, 32'h3409_8000);

        cycle(1, 32'h1234_5678, 10, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_instr", instr, 0);
        chk("arst_words", 32'(word_cnt), 0);
        chk("arst_pairs", 32'(pair_cnt), 0);
        q.delete();
        m_words = 0;
        m_pairs = 0;
        #2 rst_n = 1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] v;
            case ($urandom_range(0, 4))
                0: v = {{16{$urandom_range(0, 1) == 1}}, 16'($urandom)};
                1: v = {16'd0, 1'b1, 15'($urandom)};
                2: v = {16'($urandom), 16'd0};
                3: v = {16'($urandom_range(1, 32'hFFFE)), 16'($urandom_range(1, 32'hFFFF))};
                default: v = $urandom;
            endcase
            cycle($urandom_range(0, 3) != 0, v, 5'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imm_load_expander.md
# imm_load_expander

Inverse of the immediate extension path: takes a full 32-bit constant and a destination register, and emits the shortest MIPS instruction sequence that rebuilds that constant in the register. One or two words are produced, using `addiu`, `ori` or `lui`+`ori`. The block sits in the instruction-generation side of the test/boot infrastructure and feeds instruction words into instruction memory or a loader. Words flow through a valid/ready handshake on both the input and the output.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating statistics counters.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  request carries a valid `Value`/`Rt`.
- `InReady`  out  1  block can accept a request this cycle.
- `Value`  in  32  constant to materialise.
- `Rt`  in  5  destination register number.
- `OutValid`  out  1  `Instr` holds a valid word.
- `OutReady`  in  1  consumer takes `Instr` this cycle.
- `Instr`  out  32  emitted MIPS instruction word.
- `Last`  out  1  `Instr` is the final word of the current sequence.
- `WordCnt`  out  CNT_W  total words emitted; saturates at all-ones.
- `PairCnt`  out  CNT_W  number of two-word expansions; saturates at all-ones.

## Operation
Classification is performed on the latched `Value` (V). The first matching rule wins.
- **SEXT:** `V[31:15]` is all-0 or all-1. Emit `addiu rt,$0,V[15:0]` = {6'b001001, 5'd0, Rt, V[15:0]}. One word.
- **ZEXT:** `V[31:16]==0` and `V[15]==1`. Emit `ori rt,$0,V[15:0]` = {6'b001101, 5'd0, Rt, V[15:0]}. One word.
- **HIGH:** `V[15:0]==0`. Emit `lui rt,V[31:16]` = {6'b001111, 5'd0, Rt, V[31:16]}. One word.
- **PAIR:** all other values.
  - Word 1: `lui rt,V[31:16]`.
  - Word 2: `ori rt,rt,V[15:0]` = {6'b001101, Rt, Rt, V[15:0]}.

State machine:
- **IDLE:** `InReady=1`, `OutValid=0`.
  - On `InValid`: latch V and Rt, classify, go to EMIT1.
- **EMIT1:** `OutValid=1`, `Instr` = first word, `Last`=1 unless the class is PAIR.
  - On `OutReady`: PAIR goes to EMIT2, otherwise the sequence is complete.
- **EMIT2:** `OutValid=1`, `Instr` = `ori` word, `Last=1`.
  - On `OutReady`: the sequence is complete.
- **Sequence complete:** if `InValid` is high in that same cycle, latch the new request and go to EMIT1; otherwise go to IDLE.

Handshake rules:
- `InReady` = IDLE, or (`Last` & `OutValid` & `OutReady`).
- `InReady` depends combinationally on `OutReady`; there is no path from `InValid` to any output.
- `Instr`, `Last` and the latched V/Rt stay stable while `OutValid & ~OutReady`.
- `Rt=0` is not special-cased; the words are emitted normally.

Counters:
- `WordCnt` increments by 1 on each `OutValid & OutReady`.
- `PairCnt` increments by 1 when a PAIR request is accepted.
- Both counters hold at all-ones once saturated.

## Timing
- **Reset:** while `Reset==0`, asynchronously force state=IDLE, `OutValid=0`, `Instr=0`, `Last=0`, `WordCnt=0`, `PairCnt=0`, latched V/Rt=0. `InReady` reads 1 in IDLE.
- **Reset mid-sequence:** a pending word (including EMIT2) is discarded and is not counted.
- **Latency:** request accepted in cycle N gives first word valid in N+1. For PAIR with `OutReady` held high, the second word is valid in N+2.
- **Throughput:** with `OutReady` held high, a one-word class sustains 1 word/cycle back-to-back. PAIR gives 2 words per request with no bubble.
- **Simultaneous events:** final-word handshake plus new `InValid` in the same cycle gives the new sequence's first word in the next cycle, with no IDLE cycle.

## Test plan
- **SEXT:** `Value=0xFFFF_FFFE`, `Rt=8` -> one word `0x2408_FFFE`, `Last=1`, valid the cycle after acceptance; `WordCnt=1`.
- **ZEXT vs SEXT boundary:**
  - `Value=0x0000_8000`, `Rt=9` -> `0x3409_8000` (ori).
  - `Value=0x0000_7FFF`, `Rt=9` -> `0x2409_7FFF` (addiu).
- **PAIR:** `Value=0x1234_5678`, `Rt=10` -> `0x3C0A_1234` (`Last=0`) then `0x354A_5678` (`Last=1`) on consecutive cycles; `PairCnt=1`, `WordCnt=2`.
- **HIGH:** `Value=0xABCD_0000`, `Rt=11` -> single `0x3C0B_ABCD`, `Last=1`. `Value=0` -> `0x2400_0000` plus Rt field (SEXT wins).
- **Backpressure and back-to-back:**
  - Hold `OutReady=0` for 3 cycles during EMIT1: `Instr` is stable and `InReady=0`.
  - Then assert `OutReady` with a new `InValid` on the final word: the new request's first word appears next cycle.
- **Reset:**
  - Assert `Reset=0` asynchronously (mid-cycle) in EMIT2: outputs are immediately 0 and counters clear.
  - After release, `InReady=1` and no stale `ori` word is emitted.
